// File: rtl/shazam_spi_pkg.sv
// rtl/shazam_spi_pkg.sv - shared types and defaults for the SPI frame receiver
package shazam_spi_pkg;

    localparam int SPI_WORD_WIDTH  = 16;
    localparam int SPI_FRAME_WORDS = 512;
    localparam int SPI_INDEX_WIDTH = 10;

    typedef logic [SPI_WORD_WIDTH-1:0] spi_word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } spi_rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with comb read port, pop-before-push when full
module sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             wr_accept
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             empty, full, push, pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = rd_ready && !empty;
    assign push  = wr_valid && (!full || pop);

    assign rd_valid  = !empty;
    assign rd_data   = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_accept = push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/spi_frame_receiver.sv
// rtl/spi_frame_receiver.sv - oversampled SPI mode-0 frame receiver; SPI_RX_FIFO_EN adds an output FIFO
module spi_frame_receiver
    import shazam_spi_pkg::*;
#(
    parameter int WORD_WIDTH  = SPI_WORD_WIDTH,
    parameter int FRAME_WORDS = SPI_FRAME_WORDS,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic [9:0]            out_index,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic                  overrun
);

    localparam int BW = $clog2(WORD_WIDTH);
    localparam int CW = 11;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s, sclk_rise, cs_rise, cs_fall;

    spi_rx_state_t          state_q, state_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]          word_cnt_q, word_cnt_d;
    logic [WORD_WIDTH-1:0]  shift_q, shift_d;
    logic                   word_pend_q, word_pend_d;
    logic                   overflow, emit_valid, done_evt, err_evt;
    logic [9:0]             emit_index;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s && !sclk_prev_q;
    assign cs_rise   = cs_s && !cs_prev_q;
    assign cs_fall   = !cs_s && cs_prev_q;

    // A completed word is emitted one clk after its last bit; past the frame end it is dropped.
    assign overflow   = word_pend_q && (word_cnt_q == CW'(FRAME_WORDS));
    assign emit_valid = word_pend_q && !overflow;
    assign emit_index = word_cnt_q[9:0];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        shift_d     = shift_q;
        word_pend_d = 1'b0;
        done_evt    = 1'b0;
        err_evt     = 1'b0;
        if (emit_valid) word_cnt_d = word_cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end
            end
            ACTIVE: begin
                // cs rise outranks a coincident sclk rise.
                if (cs_rise) begin
                    if (bit_cnt_q == '0 && !overflow && word_cnt_d == CW'(FRAME_WORDS)) done_evt = 1'b1;
                    else err_evt = 1'b1;
                    state_d = IDLE;
                end else if (overflow) begin
                    state_d = DRAIN;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[WORD_WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == BW'(WORD_WIDTH-1)) begin
                        bit_cnt_d   = '0;
                        word_pend_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (cs_rise) begin
                    err_evt = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            shift_q     <= '0;
            word_pend_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            shift_q     <= shift_d;
            word_pend_q <= word_pend_d;
        end
    end

`ifdef SPI_RX_FIFO_EN
    logic                     fifo_valid, fifo_accept;
    logic [WORD_WIDTH+9:0]    fifo_rdata;
    logic                     done_pend_q, done_pend_d;
    logic                     frame_done_q, frame_done_d;
    logic                     frame_error_q;
    logic                     overrun_q, overrun_d;

    sync_fifo #(.WIDTH(WORD_WIDTH + 10), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .wr_valid  (emit_valid),
        .wr_data   ({emit_index, shift_q}),
        .rd_ready  (out_ready),
        .rd_valid  (fifo_valid),
        .rd_data   (fifo_rdata),
        .wr_accept (fifo_accept)
    );

    // frame_done waits for the sink to drain the frame's words.
    always_comb begin
        done_pend_d  = done_pend_q | done_evt;
        frame_done_d = 1'b0;
        if (done_pend_q && !fifo_valid && !emit_valid && !err_evt) begin
            frame_done_d = 1'b1;
            done_pend_d  = done_evt;
        end
        overrun_d = overrun_q | (emit_valid & ~fifo_accept);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_pend_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            done_pend_q   <= done_pend_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= err_evt;
            overrun_q     <= overrun_d;
        end
    end

    assign out_valid   = fifo_valid;
    assign out_data    = fifo_valid ? fifo_rdata[WORD_WIDTH-1:0] : '0;
    assign out_index   = fifo_valid ? fifo_rdata[WORD_WIDTH+9:WORD_WIDTH] : '0;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
`else
    logic                  out_valid_q;
    logic [WORD_WIDTH-1:0] out_data_q;
    logic [9:0]            out_index_q;
    logic                  frame_done_q, frame_error_q;
    logic                  unused_ready;
    localparam int         UNUSED_DEPTH = FIFO_DEPTH;

    assign unused_ready = out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_index_q   <= '0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            out_valid_q   <= emit_valid;
            if (emit_valid) begin
                out_data_q  <= shift_q;
                out_index_q <= emit_index;
            end
            frame_done_q  <= done_evt;
            frame_error_q <= err_evt;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_index   = out_index_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign overrun     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb/tb_spi_frame_receiver.sv - scoreboard bench for spi_frame_receiver
module tb_spi_frame_receiver;

    localparam int WW   = 16;
    localparam int FW   = 64;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [9:0]  out_index;
    logic        out_valid, frame_done, frame_error, overrun;

    spi_frame_receiver #(
        .WORD_WIDTH(WW), .FRAME_WORDS(FW), .SYNC_STAGES(SYNC), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi),
        .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
        .out_ready(out_ready), .frame_done(frame_done), .frame_error(frame_error),
        .overrun(overrun)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int exp_done = 0, exp_err = 0, got_done = 0, got_err = 0;
    int last_rise_cyc = 0, last_pop_cyc = 0;
    int half = 4;
    logic prev_done = 1'b0, prev_err = 1'b0;
    logic [25:0] exp_q[$];
    logic [25:0] e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got idx %0d data %0h expected none", out_index, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_index", 32'(out_index), 32'(e[25:16]));
                    check("out_data", 32'(out_data), 32'(e[15:0]));
                    last_pop_cyc = cyc;
                end
            end
            if (frame_done) begin
                got_done++;
                check("done_err_exclusive", 32'(frame_error), 0);
                check("done_one_cycle", 32'(prev_done), 0);
            end
            if (frame_error) begin
                got_err++;
                check("err_one_cycle", 32'(prev_err), 0);
            end
            prev_done = frame_done;
            prev_err  = frame_error;
        end else begin
            prev_done = 1'b0;
            prev_err  = 1'b0;
        end
    end

    task automatic spi_bit(input logic b);
        mosi = b;
        repeat (half) @(posedge clk);
        #2 sclk = 1'b1;
        last_rise_cyc = cyc;
        repeat (half) @(posedge clk);
        #2 sclk = 1'b0;
    endtask

    task automatic spi_word(input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) spi_bit(w[15-i]);
    endtask

    task automatic cs_begin();
        repeat (4) @(posedge clk);
        #2 cs = 1'b0;
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic cs_end();
        repeat (4) @(posedge clk);
        #2 cs = 1'b1;
        repeat (12) @(posedge clk);
        #2;
    endtask

    task automatic end_checks(input string tag);
        check($sformatf("%s_queue_empty", tag), 32'(exp_q.size()), 0);
        check($sformatf("%s_done_count", tag), 32'(got_done), 32'(exp_done));
        check($sformatf("%s_err_count", tag), 32'(got_err), 32'(exp_err));
    endtask

    // Model: words up to the frame length are delivered in order with their position;
    // only an exact-length frame with no partial word completes cleanly.
    task automatic run_frame(input int nwords, input int tail_bits, input bit rnd);
        logic [15:0] w;
        cs_begin();
        for (int i = 0; i < nwords; i++) begin
            w = rnd ? 16'($urandom) : 16'(i);
            if (i < FW) exp_q.push_back({10'(i), w});
            spi_word(w, 16);
        end
        if (tail_bits > 0) spi_word(16'($urandom), tail_bits);
        if (nwords == FW && tail_bits == 0) exp_done++;
        else exp_err++;
        cs_end();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_index", 32'(out_index), 0);
        check("rst_flags", {29'd0, frame_done, frame_error, overrun}, 0);
        reset = 1'b1;

        half = 4;
        run_frame(FW, 0, 1'b0);
        end_checks("full_frame_slow");

        half = 2;
        cs_begin();
        exp_q.push_back({10'd0, 16'hA5C3});
        spi_word(16'hA5C3, 16);
        exp_err++;
        cs_end();
        check("latency", 32'(last_pop_cyc - last_rise_cyc), 32'(SYNC + 2));
        end_checks("single_word");

        half = $urandom_range(2, 4);
        run_frame(3, 7, 1'b1);
        end_checks("partial_word");
        half = $urandom_range(2, 4);
        run_frame(FW, 0, 1'b1);
        end_checks("after_partial");

        half = 2;
        run_frame(FW + 1, 0, 1'b1);
        end_checks("long_frame");

        cs_begin();
        for (int i = 0; i < 40; i++) begin
            e[15:0] = 16'($urandom);
            exp_q.push_back({10'(i), e[15:0]});
            spi_word(e[15:0], 16);
        end
        spi_word(16'hFFFF, 5);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_data", 32'(out_data), 0);
        check("async_rst_index", 32'(out_index), 0);
        check("async_rst_flags", {29'd0, frame_done, frame_error, overrun}, 0);
        cs = 1'b1;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        end_checks("mid_reset");
        half = $urandom_range(2, 4);
        run_frame(FW, 0, 1'b1);
        end_checks("after_reset");
        check("overrun_clear", 32'(overrun), 0);

`ifdef SPI_RX_FIFO_EN
        half = 2;
        out_ready = 1'b0;
        cs_begin();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) exp_q.push_back({10'(i), 16'(i)});
            spi_word(16'(i), 16);
        end
        exp_err++;
        cs_end();
        check("fifo_overrun", 32'(overrun), 1);
        check("fifo_held_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        end_checks("fifo_backpressure");
        check("fifo_overrun_sticky", 32'(overrun), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
